mem_bus_arbiter: RTL

- Round-robin arbiter sharing one ack-handshake memory port (addr/data/we/rd/ack, as used by mmu and ddr3_dev) among NUM_REQ requesters.
- Typical use: requester 0 = instruction fetch path, requester 1 = data_cache/mmu path, both reaching ddr3_dev.
- Sits between the requesters and the mmu/ddr3_dev port in the clk_sys domain.
- One transaction outstanding at a time. Address, write data and command are registered on the downstream side.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_rr_picker.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory-bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned DEFAULT_NUM_REQ        = 2;
    localparam int unsigned DEFAULT_DATA_W         = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

    // Read data returned to a requester whose transaction was aborted.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index after last_grant, modulo NUM_REQ.
module mem_bus_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // k = NUM_REQ wraps back to last_grant itself, so it has lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one ack-handshake memory port among NUM_REQ requesters.
// Optional BUSY timeout abort is enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0]        req_rd_i,
    output logic [DATA_W-1:0]         req_data_o,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [DATA_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         data_o,
    input  logic [DATA_W-1:0]         data_i,
    output logic                      we_o,
    output logic                      rd_o,
    input  logic                      ack_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] req_any;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_we;
    logic               sel_rd;

    assign req_any = req_rd_i | req_we_i;

    mem_bus_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_any),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Steer the winning requester's slice onto the downstream registers.
    always_comb begin
        pick_idx = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        sel_rd   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = IDX_W'(i);
                sel_addr = req_addr_i[i*DATA_W +: DATA_W];
                sel_data = req_data_i[i*DATA_W +: DATA_W];
                sel_we   = req_we_i[i];
                sel_rd   = req_rd_i[i];
            end
        end
    end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] busy_cnt;
    logic            timeout;

    // Fires on the last of TIMEOUT_CYCLES consecutive BUSY cycles without ack_i.
    assign timeout = (busy_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_o    <= '0;
            addr_o     <= '0;
            data_o     <= '0;
            we_o       <= 1'b0;
            rd_o       <= 1'b0;
            req_data_o <= '0;
            req_ack_o  <= '0;
            busy_o     <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            busy_cnt   <= '0;
            err_o      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        addr_o     <= sel_addr;
                        data_o     <= sel_data;
                        we_o       <= sel_we;
                        rd_o       <= sel_rd & ~sel_we;
                        grant_o    <= pick_grant;
                        last_grant <= pick_idx;
                        busy_o     <= 1'b1;
                        state      <= BUSY;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                        busy_cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (ack_i) begin
                        if (rd_o) begin
                            req_data_o <= data_i;
                        end
                        we_o      <= 1'b0;
                        rd_o      <= 1'b0;
                        req_ack_o <= grant_o;
                        state     <= RESP;
                    end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    else if (timeout) begin
                        we_o       <= 1'b0;
                        rd_o       <= 1'b0;
                        req_data_o <= DATA_W'(TIMEOUT_DATA);
                        req_ack_o  <= grant_o;
                        err_o      <= 1'b1;
                        state      <= RESP;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    req_ack_o <= '0;
                    grant_o   <= '0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    err_o     <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
